pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register that replaces the hand-written per-stage latches
//  (id/ex, ex/mem, mem/wb). Carries an opaque payload plus a valid bit from stage STAGE to STAGE+1.
//  Honours the global 6-bit stall vector, inserts bubbles, and takes a flush for exceptions/branches.
//  Keeps multi-cycle-op scratch state (e.g. madd/div hilo + cycle count) alive across stalls.
//  Exports a hold/bubble state and a saturating stall counter for perf monitoring.
// PARAMETERS
//  DATA_W      64     payload width (packed stage fields)
//  NOP_PAYLOAD 0      payload value presented while a bubble is held (DATA_W bits)
//  SCR_W       64     scratch (multi-cycle accumulator) width
//  CNT_W       2      multi-cycle step counter width
//  STALL_W     6      width of global stall vector
//  STAGE       3      index of upstream stage in stall vector; STAGE+1 < STALL_W required
//  PERF_W      16     width of stall-cycle counter
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        async reset, active-high
//  stall        in   STALL_W  global stall vector, bit=1 means stop
//  flush        in   1        kill contents (exception/branch redirect)
//  in_valid     in   1        upstream slot holds a real instruction
//  in_payload   in   DATA_W   upstream stage outputs
//  scratch_i    in   SCR_W    multi-cycle scratch from upstream stage
//  cnt_i        in   CNT_W    multi-cycle step count from upstream stage
//  out_valid    out  1        registered valid to downstream
//  out_payload  out  DATA_W   registered payload to downstream
//  scratch_o    out  SCR_W    scratch fed back to upstream stage
//  cnt_o        out  CNT_W    step count fed back to upstream stage
//  state_o      out  2        00 RUN, 01 HOLD, 10 BUBBLE
//  stall_cnt_o  out  PERF_W   saturating count of cycles spent not in RUN
// BEHAVIOUR
//  - Reset (async, asserted rst): out_valid=0, out_payload=NOP_PAYLOAD, scratch_o=0, cnt_o=0,
//    state_o=RUN, stall_cnt_o=0. Effective immediately, no clock required. Release is synchronous.
//  - Let up=stall[STAGE], dn=stall[STAGE+1]. Per rising edge, priority is highest first:
//    1 flush: out_valid=0, payload=NOP_PAYLOAD, scratch/cnt=0, state->RUN. Overrides any stall.
//    2 up&!dn (BUBBLE): out_valid=0, payload=NOP_PAYLOAD, scratch_o<=scratch_i, cnt_o<=cnt_i.
//    3 !up (ADVANCE, state->RUN): out_valid<=in_valid, payload<=in_payload, scratch/cnt<=0.
//    4 up&dn (HOLD): valid/payload unchanged, scratch_o<=scratch_i, cnt_o<=cnt_i.
//  - !up&dn is an illegal stall pattern (stall vector is monotonic). Treat it as ADVANCE.
//    Bench flags it with an assertion.
//  - FSM: RUN->BUBBLE on case2, RUN->HOLD on case4. HOLD<->BUBBLE follows cases 2/4.
//    Any state->RUN on case 3 or flush.
//  - stall_cnt_o increments by 1 on each edge whose next state is not RUN.
//    It saturates at all-ones and is cleared only by rst.
//  - Latency: 1 cycle from input to output on ADVANCE. There is no combinational in->out path.
//  - Bubble payload is always NOP_PAYLOAD, never stale data. Consumers may rely on out_valid alone.
//  - Scratch semantics: during a stall the upstream multi-cycle unit sees its own state echoed
//    back with 1-cycle delay. On ADVANCE the scratch is zeroed so the next op starts clean.
//  - Flush asserted together with rst: rst wins. rst asserted mid-stall: all state discarded.
// STRUCTURE
//  - Shared defines package: stall/nostop encodings, state codes RUN/HOLD/BUBBLE,
//    NOP payload constants per stage.
//  - Single module. The data path is one always block with async reset.
//  - Optional sub-module: sat_counter (PERF_W, inc, async clr), reusable by other perf counters.
//  - Stage-specific wrappers pack/unpack named fields into in_payload/out_payload.
// TESTING
//  - rst=1 mid-cycle with out_payload=0xDEAD -> out_payload=NOP_PAYLOAD and out_valid=0 at once.
//  - stall=000000, in_valid=1, in_payload=0x1234 -> next edge out_valid=1, out_payload=0x1234,
//    scratch_o=0, state_o=RUN.
//  - stall=001000 (STAGE=3), scratch_i=0xABCD, cnt_i=1 -> out_valid=0, payload=NOP,
//    scratch_o=0xABCD, cnt_o=1, state_o=BUBBLE.
//  - Hold: load 0x55, then stall=011000 for 3 cycles with scratch_i=1,2,3 -> payload stays 0x55,
//    scratch_o tracks 1,2,3 one cycle late, state_o=HOLD, stall_cnt_o=3.
//  - flush=1 with stall=011000 -> out_valid=0, scratch_o=0, state_o=RUN.
//    stall_cnt_o keeps its value.
//  - PERF_W=2, stall held 6 cycles -> stall_cnt_o saturates at 3 and holds after release.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for inter-stage pipeline registers: stall encodings, stage
// state codes, per-edge operation decode and NOP payloads for the stock stages.
package pipe_stage_reg_pkg;

  localparam logic STALL_STOP = 1'b1;
  localparam logic STALL_GO   = 1'b0;

  // Externally visible state codes: 00 RUN, 01 HOLD, 10 BUBBLE.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HOLD   = 2'b01,
    ST_BUBBLE = 2'b10
  } stage_state_e;

  typedef enum logic [1:0] {
    OP_FLUSH   = 2'd0,
    OP_BUBBLE  = 2'd1,
    OP_ADVANCE = 2'd2,
    OP_HOLD    = 2'd3
  } stage_op_e;

  localparam logic [63:0] NOP_ID_EX  = 64'h0;
  localparam logic [63:0] NOP_EX_MEM = 64'h0;
  localparam logic [63:0] NOP_MEM_WB = 64'h0;

  // Priority: flush, then bubble, then advance, then hold. The illegal
  // non-monotonic pattern (upstream running, downstream stopped) advances.
  function automatic stage_op_e decode_op(input logic flush, input logic up,
                                          input logic dn);
    if (flush)                             return OP_FLUSH;
    if (up == STALL_STOP && dn == STALL_GO) return OP_BUBBLE;
    if (up == STALL_GO)                    return OP_ADVANCE;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with asynchronous clear, shared by perf monitors.
// Counts one per enabled edge and sticks at all-ones until cleared.
module pipe_stage_reg_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register between stage STAGE and STAGE+1 with stall,
// bubble, flush, multi-cycle scratch echo and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0,
  parameter int                SCR_W       = 64,
  parameter int                CNT_W       = 2,
  parameter int                STALL_W     = 6,
  parameter int                STAGE       = 3,
  parameter int                PERF_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_payload,
  input  logic [SCR_W-1:0]   scratch_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_payload,
  output logic [SCR_W-1:0]   scratch_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [1:0]         state_o,
  output logic [PERF_W-1:0]  stall_cnt_o
);

  // Valid semantics: out_valid qualifies out_payload for exactly the cycle it
  // is high; no ready exists, back-pressure arrives only via the stall vector.
  // While out_valid is low the payload is always NOP_PAYLOAD or the last
  // advanced (invalid) slot, so consumers may rely on out_valid alone.

  logic         up;
  logic         dn;
  logic         stall_unused;
  stage_op_e    op;
  stage_state_e state_q;
  stage_state_e state_d;

  assign up           = stall[STAGE];
  assign dn           = stall[STAGE+1];
  assign stall_unused = ^stall;
  assign op           = decode_op(flush, up, dn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (op)
      OP_FLUSH:   state_d = ST_RUN;
      OP_BUBBLE:  state_d = ST_BUBBLE;
      OP_ADVANCE: state_d = ST_RUN;
      OP_HOLD:    state_d = ST_HOLD;
      default:    state_d = ST_RUN;
    endcase
  end

  // Scratch is echoed while stalled so a multi-cycle unit keeps its progress,
  // and zeroed on advance/flush so the next op starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_payload <= NOP_PAYLOAD;
      scratch_o   <= '0;
      cnt_o       <= '0;
    end else begin
      case (op)
        OP_FLUSH: begin
          out_valid   <= 1'b0;
          out_payload <= NOP_PAYLOAD;
          scratch_o   <= '0;
          cnt_o       <= '0;
        end
        OP_BUBBLE: begin
          out_valid   <= 1'b0;
          out_payload <= NOP_PAYLOAD;
          scratch_o   <= scratch_i;
          cnt_o       <= cnt_i;
        end
        OP_ADVANCE: begin
          out_valid   <= in_valid;
          out_payload <= in_payload;
          scratch_o   <= '0;
          cnt_o       <= '0;
        end
        default: begin
          scratch_o <= scratch_i;
          cnt_o     <= cnt_i;
        end
      endcase
    end
  end

  pipe_stage_reg_sat_counter #(
    .W(PERF_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr  (rst),
    .inc  (state_d != ST_RUN),
    .count(stall_cnt_o)
  );

  assign state_o = state_q;

endmodule
